seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 14 +
 rtl/led.sv | 31 +++
 rtl/seg_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// state encoding, anode idle pattern and default timing.
package seg_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam logic [7:0] ANODES_OFF = 8'hFF;

  localparam int DWELL_DEF = 50000;
  localparam int GUARD_DEF = 500;

endpackage

// File: rtl/led.sv
// Hex nibble to seven-segment decoder, segments a..g active-high, bit6 = a.
module led (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: a default before the case keeps this purely combinational (no latch).
    seg = 7'b0000000;
    case (hex)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with guard blanking, leading-zero
// suppression and a double-buffered frame that only swaps at frame start.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int DWELL    = DWELL_DEF,
  parameter int GUARD    = GUARD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        lz_en,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        ack,
  output logic        pending
);

  localparam int MAXC = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [2:0]    LAST      = 3'(N_DIGITS - 1);
  localparam logic [CW-1:0] GUARD_END = CW'(GUARD - 1);
  localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);

  logic [1:0]    state, state_n;
  logic [2:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          frame_start, commit;
  logic [31:0]   disp_data, pend_data;
  logic [7:0]    disp_dp, pend_dp;
  logic          lz_q;
  logic [2:0]    top_nz;
  logic [3:0]    cur_nib;
  logic [6:0]    dec_seg;

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    cnt_n       = cnt + CW'(1);
    frame_start = 1'b0;
    if (!enable) begin
      state_n = ST_IDLE;
      idx_n   = 3'd0;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n     = ST_BLANK;
          idx_n       = 3'd0;
          cnt_n       = '0;
          frame_start = 1'b1;
        end
        ST_BLANK: begin
          if (cnt == GUARD_END) begin
            state_n = ST_SHOW;
            cnt_n   = '0;
          end
        end
        ST_SHOW: begin
          if (cnt == DWELL_END) begin
            state_n = ST_BLANK;
            cnt_n   = '0;
            if (idx == LAST) begin
              idx_n       = 3'd0;
              frame_start = 1'b1;
            end else begin
              idx_n = idx + 3'd1;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          idx_n   = 3'd0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Swapping buffers only at frame start is what keeps a frame from tearing.
  assign commit = frame_start & pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      cnt       <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
      pend_data <= '0;
      pend_dp   <= '0;
      pending   <= 1'b0;
      ack       <= 1'b0;
      lz_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so the commit reads the old pending frame even when
      // a load lands on the same edge.
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      ack   <= commit;
      lz_q  <= lz_en;
      if (commit) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
      end
      if (load) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
        pending   <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  // Most significant nonzero displayed digit; digit 0 is the floor.
  always_comb begin
    top_nz = 3'd0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if (disp_data[4*i +: 4] != 4'd0) top_nz = 3'(i);
    end
  end

  assign cur_nib = disp_data[{idx, 2'b00} +: 4];

  led u_led (
    .hex (cur_nib),
    .seg (dec_seg)
  );

  always_comb begin
    an  = ANODES_OFF;
    seg = 7'b0000000;
    dp  = 1'b0;
    if (state == ST_SHOW && !(lz_q && (idx > top_nz))) begin
      an[idx] = 1'b0;
      seg     = dec_seg;
      dp      = disp_dp[idx];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: vector table plus scoreboarded scan
// sequences for frame commit, enable drop and load-on-commit corner cases.
module tb_seg_scan_ctrl;

  localparam int N     = 8;
  localparam int DW    = 4;
  localparam int GD    = 2;
  localparam int SLOT  = GD + DW;
  localparam int FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  dp_in = '0;
  logic        lz_en = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        ack;
  logic        pending;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.N_DIGITS(N), .DWELL(DW), .GUARD(GD)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .load    (load),
    .data_in (data_in),
    .dp_in   (dp_in),
    .lz_en   (lz_en),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .ack     (ack),
    .pending (pending)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_ack = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h7E; 4'h1: s = 7'h30; 4'h2: s = 7'h6D; 4'h3: s = 7'h79;
      4'h4: s = 7'h33; 4'h5: s = 7'h5B; 4'h6: s = 7'h5F; 4'h7: s = 7'h70;
      4'h8: s = 7'h7F; 4'h9: s = 7'h7B; 4'hA: s = 7'h77; 4'hB: s = 7'h1F;
      4'hC: s = 7'h4E; 4'hD: s = 7'h3D; 4'hE: s = 7'h4F; default: s = 7'h47;
    endcase
    return s;
  endfunction

  function automatic int msnz(input logic [31:0] d);
    int m = 0;
    for (int i = 1; i < N; i++) if (d[4*i +: 4] != 4'd0) m = i;
    return m;
  endfunction

  // Reference model of the display/pending buffers and frame position.
  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ack;
    logic       pend;
    bit         chk_seg;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_disp = '0, m_pend = '0;
  logic [7:0]  m_ddp = '0, m_pdp = '0;
  bit          m_pv = 1'b0;
  int          m_p = 0;
  int          last_p = -1;

  task automatic tick(input bit en, input bit ld, input logic [31:0] d, input logic [7:0] dpv);
    exp_t e;
    int   dg, r;
    bit   commit;
    enable  = en;
    load    = ld;
    data_in = d;
    dp_in   = dpv;
    e.an = 8'hFF; e.seg = 7'd0; e.dp = 1'b0; e.chk_seg = 1'b1;
    commit = 1'b0;
    if (en) begin
      if (m_p == 0 && m_pv) begin
        m_disp = m_pend; m_ddp = m_pdp; m_pv = 1'b0; commit = 1'b1;
      end
      dg = m_p / SLOT;
      r  = m_p % SLOT;
      if (r >= GD) begin
        if (lz_en && dg > msnz(m_disp)) begin
          e.chk_seg = 1'b0;
        end else begin
          e.an  = ~(8'b1 << dg);
          e.seg = ref_seg(m_disp[4*dg +: 4]);
          e.dp  = m_ddp[dg];
        end
      end
      last_p = m_p;
      m_p    = (m_p + 1) % FRAME;
    end else begin
      last_p = -1;
      m_p    = 0;
    end
    if (ld) begin
      m_pend = d; m_pdp = dpv; m_pv = 1'b1;
    end
    e.ack  = commit;
    e.pend = m_pv;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    load = 1'b0;
    e = sbq.pop_front();
    check("an", an, e.an);
    if (e.chk_seg) begin
      check("seg", seg, e.seg);
      check("dp", dp, e.dp);
    end
    check("ack", ack, e.ack);
    check("pending", pending, e.pend);
    if (ack) n_ack++;
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 2 * FRAME && last_p != target; k++) tick(1'b1, 1'b0, '0, '0);
  endtask

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dpv;
    bit          lz;
    int          digit;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dpo;
    bit          chk_seg;
  } vec_t;

  vec_t vt[11];
  int   a0;

  initial begin
    vt[0]  = '{32'h0123ABCD, 8'h00, 1'b0, 0, 8'hFE, 7'b0111101, 1'b0, 1'b1};
    vt[1]  = '{32'h0123ABCD, 8'h00, 1'b0, 7, 8'h7F, 7'b1111110, 1'b0, 1'b1};
    vt[2]  = '{32'h0123ABCD, 8'h00, 1'b0, 1, 8'hFD, 7'b1001110, 1'b0, 1'b1};
    vt[3]  = '{32'h000000A5, 8'h00, 1'b1, 0, 8'hFE, 7'b1011011, 1'b0, 1'b1};
    vt[4]  = '{32'h000000A5, 8'h00, 1'b1, 1, 8'hFD, 7'b1110111, 1'b0, 1'b1};
    vt[5]  = '{32'h000000A5, 8'h00, 1'b1, 2, 8'hFF, 7'b0000000, 1'b0, 1'b0};
    vt[6]  = '{32'h000000A5, 8'h00, 1'b1, 7, 8'hFF, 7'b0000000, 1'b0, 1'b0};
    vt[7]  = '{32'h00000000, 8'h01, 1'b1, 0, 8'hFE, 7'b1111110, 1'b1, 1'b1};
    vt[8]  = '{32'h00000000, 8'h00, 1'b1, 1, 8'hFF, 7'b0000000, 1'b0, 1'b0};
    vt[9]  = '{32'h00F0000F, 8'h00, 1'b1, 4, 8'hEF, 7'b1111110, 1'b0, 1'b1};
    vt[10] = '{32'h12345678, 8'h80, 1'b0, 7, 8'h7F, 7'b0110000, 1'b1, 1'b1};

    // Reset overrides enable and load.
    rst = 1'b1; enable = 1'b1; load = 1'b1; data_in = 32'hFFFFFFFF; dp_in = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("rst_an", an, 8'hFF);
      check("rst_seg", seg, 7'd0);
      check("rst_dp", dp, 1'b0);
      check("rst_ack", ack, 1'b0);
      check("rst_pending", pending, 1'b0);
    end
    rst = 1'b0;
    tick(1'b0, 1'b0, '0, '0);

    // Vector table: one frame per record, sampled on the digit's first SHOW cycle.
    foreach (vt[v]) begin
      lz_en = vt[v].lz;
      tick(1'b0, 1'b1, vt[v].data, vt[v].dpv);
      tick(1'b1, 1'b0, '0, '0);
      run_to(vt[v].digit * SLOT + GD);
      check($sformatf("vec%0d_an", v), an, vt[v].an);
      if (vt[v].chk_seg) begin
        check($sformatf("vec%0d_seg", v), seg, vt[v].seg);
        check($sformatf("vec%0d_dp", v), dp, vt[v].dpo);
      end
      tick(1'b0, 1'b0, '0, '0);
    end

    // Basic scan over two frames.
    lz_en = 1'b0;
    tick(1'b0, 1'b0, '0, '0);
    tick(1'b0, 1'b1, 32'h0123ABCD, 8'h00);
    check("basic_pending", pending, 1'b1);
    a0 = n_ack;
    tick(1'b1, 1'b0, '0, '0);
    check("basic_ack", ack, 1'b1);
    run_to(GD);
    check("basic_d0_an", an, 8'hFE);
    check("basic_d0_seg", seg, 7'b0111101);
    run_to(7 * SLOT + GD);
    check("basic_d7_an", an, 8'h7F);
    check("basic_d7_seg", seg, 7'b1111110);
    run_to(FRAME - 1);
    run_to(GD);
    check("basic_repeat_seg", seg, 7'b0111101);
    check("basic_ack_count", n_ack - a0, 1);

    // Mid-frame loads: latest wins, visible only after the wrap.
    run_to(10);
    tick(1'b1, 1'b1, 32'h11111111, 8'h00);
    run_to(20);
    a0 = n_ack;
    tick(1'b1, 1'b1, 32'h22222222, 8'h00);
    run_to(FRAME - 1);
    check("upd_no_early_ack", n_ack - a0, 0);
    run_to(GD);
    check("upd_seg", seg, 7'b1101101);
    run_to(FRAME - 1);
    check("upd_ack_count", n_ack - a0, 1);
    check("upd_pending", pending, 1'b0);

    // Enable drop during digit 3 with a frame pending.
    run_to(8);
    tick(1'b1, 1'b1, 32'h33333333, 8'h00);
    run_to(3 * SLOT + GD);
    check("drop_show_an", an, 8'hF7);
    tick(1'b0, 1'b0, '0, '0);
    check("drop_an", an, 8'hFF);
    check("drop_seg", seg, 7'd0);
    check("drop_pending_kept", pending, 1'b1);
    a0 = n_ack;
    tick(1'b1, 1'b0, '0, '0);
    check("reen_ack", ack, 1'b1);
    check("reen_blank_an", an, 8'hFF);
    run_to(GD);
    check("reen_d0_an", an, 8'hFE);
    check("reen_d0_seg", seg, 7'b1111001);
    check("reen_ack_count", n_ack - a0, 1);

    // Load landing on the commit edge.
    run_to(10);
    tick(1'b1, 1'b1, 32'h44444444, 8'h00);
    run_to(FRAME - 1);
    a0 = n_ack;
    tick(1'b1, 1'b1, 32'h55555555, 8'h00);
    check("coll_ack", ack, 1'b1);
    check("coll_pending", pending, 1'b1);
    run_to(GD);
    check("coll_old_seg", seg, 7'b0110011);
    run_to(FRAME - 1);
    tick(1'b1, 1'b0, '0, '0);
    check("coll_ack2", ack, 1'b1);
    run_to(GD);
    check("coll_new_seg", seg, 7'b1011011);
    check("coll_ack_count", n_ack - a0, 2);
    check("coll_pending_clr", pending, 1'b0);

    tick(1'b0, 1'b0, '0, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
